// File: rtl/toysram_16x12_port_ctl.sv
// Port controller for a 16-row x 12-bit toy SRAM subarray: two pipelined read
// ports and one sequenced write port. Wordline bit for row r is bit 15-r.
module toysram_16x12_port_ctl #(
    parameter int unsigned WR_PULSE_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd0_req,
    input  logic [3:0]  rd0_addr,
    output logic        rd0_val,
    output logic [11:0] rd0_data,
    input  logic        rd1_req,
    input  logic [3:0]  rd1_addr,
    output logic        rd1_val,
    output logic [11:0] rd1_data,
    input  logic        wr_req,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_busy,
    output logic        wr_ack,
    output logic [15:0] RWL0,
    output logic [15:0] RWL1,
    output logic [15:0] WWL,
    output logic [11:0] WBL,
    output logic [11:0] WBLb,
    input  logic [11:0] RBL0,
    input  logic [11:0] RBL1
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} wr_state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE_CYC - 1);

    wr_state_t   state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  waddr, waddr_next;
    logic [11:0] wdata, wdata_next;
    logic        writing;
    logic        rd0_hit, rd1_hit;
    logic        rd0_pend, rd1_pend;
    logic        rd0_fwd, rd1_fwd;

    function automatic logic [15:0] wl_decode(input logic [3:0] row);
        return 16'h8000 >> row;
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        waddr_next = waddr;
        wdata_next = wdata;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_next = SETUP;
                    waddr_next = wr_addr;
                    wdata_next = wr_data;
                end
            end
            SETUP: begin
                state_next = PULSE;
                cnt_next   = '0;
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Collision is judged against the write state that will be live while the
    // read wordline is up, so the colliding RWL bit is never raised.
    always_comb begin
        writing = (state_next != IDLE);
        rd0_hit = rd0_req && writing && (rd0_addr == waddr_next);
        rd1_hit = rd1_req && writing && (rd1_addr == waddr_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            waddr   <= '0;
            wdata   <= '0;
            WWL     <= '0;
            WBL     <= '0;
            WBLb    <= '0;
            wr_busy <= 1'b0;
            wr_ack  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            waddr   <= waddr_next;
            wdata   <= wdata_next;
            WWL     <= (state_next == PULSE) ? wl_decode(waddr_next) : '0;
            WBL     <= writing ? wdata_next : '0;
            WBLb    <= writing ? ~wdata_next : '0;
            wr_busy <= writing;
            wr_ack  <= (state == HOLD);
        end
    end

    // Forwarded reads take the latched write data, which cannot change
    // until the sequence has returned to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            RWL0     <= '0;
            RWL1     <= '0;
            rd0_pend <= 1'b0;
            rd1_pend <= 1'b0;
            rd0_fwd  <= 1'b0;
            rd1_fwd  <= 1'b0;
            rd0_val  <= 1'b0;
            rd1_val  <= 1'b0;
            rd0_data <= '0;
            rd1_data <= '0;
        end else begin
            RWL0     <= (rd0_req && !rd0_hit) ? wl_decode(rd0_addr) : '0;
            RWL1     <= (rd1_req && !rd1_hit) ? wl_decode(rd1_addr) : '0;
            rd0_pend <= rd0_req;
            rd1_pend <= rd1_req;
            rd0_fwd  <= rd0_hit;
            rd1_fwd  <= rd1_hit;
            rd0_val  <= rd0_pend;
            rd1_val  <= rd1_pend;
            if (rd0_pend) begin
                rd0_data <= rd0_fwd ? wdata : RBL0;
            end
            if (rd1_pend) begin
                rd1_data <= rd1_fwd ? wdata : RBL1;
            end
        end
    end

endmodule

// File: tb/tb_toysram_16x12_port_ctl.sv
// Scoreboard bench for toysram_16x12_port_ctl with a behavioural subarray that
// commits a row only after a complete write pulse.
module tb_toysram_16x12_port_ctl;

    localparam int WPC = 3;

    logic        clk;
    logic        reset;
    logic        rd0_req, rd1_req, wr_req;
    logic [3:0]  rd0_addr, rd1_addr, wr_addr;
    logic [11:0] wr_data;
    logic        rd0_val, rd1_val, wr_busy, wr_ack;
    logic [11:0] rd0_data, rd1_data;
    logic [15:0] RWL0, RWL1, WWL;
    logic [11:0] WBL, WBLb, RBL0, RBL1;

    typedef struct {
        int          cyc;
        logic [11:0] data;
    } rd_exp_t;

    rd_exp_t     q0[$];
    rd_exp_t     q1[$];
    int          ack_q[$];
    int          checks;
    int          fails;
    int          cyc;
    logic [11:0] mem [16];
    int          pcnt;
    int          prow;
    logic [11:0] pdata;

    toysram_16x12_port_ctl #(.WR_PULSE_CYC(WPC)) u_dut (
        .clk(clk), .reset(reset),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_val(rd0_val), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_val(rd1_val), .rd1_data(rd1_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_busy(wr_busy), .wr_ack(wr_ack),
        .RWL0(RWL0), .RWL1(RWL1), .WWL(WWL), .WBL(WBL), .WBLb(WBLb),
        .RBL0(RBL0), .RBL1(RBL1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [11:0] lookup(input logic [15:0] wl);
        logic [11:0] v;
        v = '0;
        for (int r = 0; r < 16; r++) begin
            if (wl[15 - r]) v = mem[r];
        end
        return v;
    endfunction

    always @(negedge clk) begin
        RBL0 = lookup(RWL0);
        RBL1 = lookup(RWL1);
    end

    // A row is committed only when WWL falls after a full-length pulse.
    always @(posedge clk) begin
        if (WWL != 16'h0) begin
            for (int r = 0; r < 16; r++) begin
                if (WWL[15 - r]) prow = r;
            end
            pdata = WBL;
            pcnt++;
        end else begin
            if (pcnt == WPC) mem[prow] = pdata;
            pcnt = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        rd_exp_t e;
        check_output("rwl0_wwl_excl", 32'(RWL0 & WWL), 32'h0);
        check_output("rwl1_wwl_excl", 32'(RWL1 & WWL), 32'h0);
        if (rd0_val) begin
            if (q0.size() == 0) begin
                check_output("rd0_unexpected_val", 32'(rd0_val), 32'h0);
            end else begin
                e = q0.pop_front();
                check_output("rd0_cycle", cyc, e.cyc);
                check_output("rd0_data", 32'(rd0_data), 32'(e.data));
            end
        end
        if (rd1_val) begin
            if (q1.size() == 0) begin
                check_output("rd1_unexpected_val", 32'(rd1_val), 32'h0);
            end else begin
                e = q1.pop_front();
                check_output("rd1_cycle", cyc, e.cyc);
                check_output("rd1_data", 32'(rd1_data), 32'(e.data));
            end
        end
        if (wr_ack) begin
            if (ack_q.size() == 0) begin
                check_output("wr_ack_unexpected", 32'(wr_ack), 32'h0);
            end else begin
                check_output("wr_ack_cycle", cyc, ack_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        checks = 0; fails = 0; cyc = 0; pcnt = 0; prow = 0; pdata = '0;
        RBL0 = '0; RBL1 = '0;
        for (int r = 0; r < 16; r++) mem[r] = 12'h300 + 12'(r);
        reset = 1'b1;
        rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        check_output("rst_wwl", 32'(WWL), 32'h0);
        check_output("rst_rwl0", 32'(RWL0), 32'h0);
        check_output("rst_rwl1", 32'(RWL1), 32'h0);
        check_output("rst_wbl", 32'(WBL), 32'h0);
        check_output("rst_wblb", 32'(WBLb), 32'h0);
        check_output("rst_busy", 32'(wr_busy), 32'h0);
        check_output("rst_ack", 32'(wr_ack), 32'h0);
        check_output("rst_rd0_data", 32'(rd0_data), 32'h0);
        check_output("rst_rd1_data", 32'(rd1_data), 32'h0);
        reset = 1'b0;
        step();

        // Write row 5 with 0xA5C and follow the SETUP/PULSE/HOLD waveform.
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 12'hA5C;
        ack_q.push_back(cyc + 1 + WPC + 2);
        step();
        wr_req = 1'b0;
        check_output("setup_wbl", 32'(WBL), 32'hA5C);
        check_output("setup_wblb", 32'(WBLb), 32'h5A3);
        check_output("setup_wwl", 32'(WWL), 32'h0);
        check_output("setup_busy", 32'(wr_busy), 32'h1);
        for (int k = 0; k < WPC; k++) begin
            step();
            check_output("pulse_wwl", 32'(WWL), 32'h0400);
            check_output("pulse_wbl", 32'(WBL), 32'hA5C);
        end
        step();
        check_output("hold_wwl", 32'(WWL), 32'h0);
        check_output("hold_wblb", 32'(WBLb), 32'h5A3);
        check_output("hold_busy", 32'(wr_busy), 32'h1);
        step();
        check_output("idle_busy", 32'(wr_busy), 32'h0);
        check_output("idle_wbl", 32'(WBL), 32'h0);
        step();

        // Both ports read row 5 in the same cycle.
        rd0_req = 1'b1; rd0_addr = 4'd5; rd1_req = 1'b1; rd1_addr = 4'd5;
        q0.push_back('{cyc + 2, 12'hA5C});
        q1.push_back('{cyc + 2, 12'hA5C});
        step();
        rd0_req = 1'b0; rd1_req = 1'b0;
        check_output("dual_rwl0", 32'(RWL0), 32'h0400);
        check_output("dual_rwl1", 32'(RWL1), 32'h0400);
        step();
        check_output("dual_rwl0_off", 32'(RWL0), 32'h0);

        // Back-to-back reads of rows 0..3 on port 0.
        for (int a = 0; a < 4; a++) begin
            rd0_req = 1'b1; rd0_addr = 4'(a);
            q0.push_back('{cyc + 2, 12'h300 + 12'(a)});
            step();
            check_output("walk_rwl0", 32'(RWL0), 32'h8000 >> a);
        end
        rd0_req = 1'b0;
        repeat (3) step();

        // Write row 7 while a second request is ignored and port 1 collides.
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 12'h123;
        ack_q.push_back(cyc + 1 + WPC + 2);
        step();
        wr_addr = 4'd9; wr_data = 12'hFFF;
        step();
        check_output("coll_wwl", 32'(WWL), 32'h0100);
        check_output("coll_wbl", 32'(WBL), 32'h123);
        wr_req = 1'b0;
        rd1_req = 1'b1; rd1_addr = 4'd7;
        q1.push_back('{cyc + 2, 12'h123});
        step();
        rd1_req = 1'b0;
        check_output("coll_rwl1", 32'(RWL1), 32'h0);
        check_output("coll_wwl2", 32'(WWL), 32'h0100);
        step();
        step();
        check_output("coll_hold_wbl", 32'(WBL), 32'h123);
        step();
        check_output("coll_idle_busy", 32'(wr_busy), 32'h0);
        repeat (2) step();
        rd0_req = 1'b1; rd0_addr = 4'd9; rd1_req = 1'b1; rd1_addr = 4'd7;
        q0.push_back('{cyc + 2, 12'h309});
        q1.push_back('{cyc + 2, 12'h123});
        step();
        rd0_req = 1'b0; rd1_req = 1'b0;
        repeat (3) step();

        // Reset in the PULSE cycle abandons the write and an in-flight read.
        wr_req = 1'b1; wr_addr = 4'd2; wr_data = 12'hBEE;
        step();
        wr_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 4'd3;
        step();
        check_output("abort_pulse_wwl", 32'(WWL), 32'h2000);
        rd0_req = 1'b0;
        reset = 1'b1;
        rd1_req = 1'b1; rd1_addr = 4'd4;
        wr_req = 1'b1; wr_addr = 4'd6; wr_data = 12'h555;
        step();
        check_output("abort_wwl", 32'(WWL), 32'h0);
        check_output("abort_wbl", 32'(WBL), 32'h0);
        check_output("abort_wblb", 32'(WBLb), 32'h0);
        check_output("abort_busy", 32'(wr_busy), 32'h0);
        check_output("abort_rd0_data", 32'(rd0_data), 32'h0);
        reset = 1'b0;
        rd1_req = 1'b0; wr_req = 1'b0;
        step();
        check_output("post_rst_busy", 32'(wr_busy), 32'h0);
        rd0_req = 1'b1; rd0_addr = 4'd2;
        q0.push_back('{cyc + 2, 12'h302});
        step();
        rd0_req = 1'b0;
        repeat (6) step();

        check_output("q0_drained", q0.size(), 32'h0);
        check_output("q1_drained", q1.size(), 32'h0);
        check_output("ack_drained", ack_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/toysram_16x12_port_ctl.md
TOYSRAM_16X12_PORT_CTL -- requirements
Module: toysram_16x12_port_ctl

Interface
REQ-001 Parameter: WR_PULSE_CYC, default 1, WWL pulse width in clk cycles; legal range 1..15.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: rd0_req  in  1  read request, port 0.
REQ-005 Port: rd0_addr  in  4  row address, port 0.
REQ-006 Port: rd0_val  out  1  rd0_data valid, one-cycle pulse.
REQ-007 Port: rd0_data  out  12  read data, port 0.
REQ-008 Port: rd1_req, rd1_addr, rd1_val, rd1_data  same directions/widths as port 0, read port 1.
REQ-009 Port: wr_req  in  1  write request; sampled only when wr_busy=0.
REQ-010 Port: wr_addr  in  4  write row address.
REQ-011 Port: wr_data  in  12  write data.
REQ-012 Port: wr_busy  out  1  write sequence in progress.
REQ-013 Port: wr_ack  out  1  one-cycle pulse at write completion.
REQ-014 Port: RWL0, RWL1  out  16 each  read wordlines to subarray, one-hot or zero.
REQ-015 Port: WWL  out  16  write wordlines to subarray, one-hot or zero.
REQ-016 Port: WBL, WBLb  out  12 each  write bitline pair to subarray.
REQ-017 Port: RBL0, RBL1  in  12 each  read bitlines from subarray.

Function
REQ-018 All subarray-facing outputs (RWL0, RWL1, WWL, WBL, WBLb) shall be driven directly from flops.
REQ-019 Read, per port p: rdp_req=1 at edge N shall assert RWLp[rdp_addr] alone during cycle N..N+1; RBLp sampled at edge N+1; rdp_val=1 and rdp_data valid during cycle N+1..N+2 (latency 2).
REQ-020 Reads shall be fully pipelined: one request per port per cycle, no stall, no ready signal; rdp_data holds last value when rdp_val=0.
REQ-021 Both ports may read the same or different rows in the same cycle independently.
REQ-022 Write FSM states: IDLE, SETUP, PULSE, HOLD.
REQ-023 IDLE: WWL=0, WBL=0, WBLb=0, wr_busy=0; wr_req=1 latches wr_addr/wr_data, next state SETUP.
REQ-024 SETUP (1 cycle): WBL=data, WBLb=~data, WWL=0, wr_busy=1; next PULSE.
REQ-025 PULSE (WR_PULSE_CYC cycles, 4-bit counter): WWL[addr]=1 only, bitlines held; next HOLD.
REQ-026 HOLD (1 cycle): WWL=0, bitlines held; next IDLE with wr_ack=1 in the first IDLE cycle.
REQ-027 Total write occupancy = WR_PULSE_CYC+2 cycles busy; new wr_req accepted in the same cycle wr_ack is high.
REQ-028 wr_req while wr_busy=1 shall be ignored (not queued); latched addr/data shall not change mid-sequence.
REQ-029 Collision: if a read's RWL cycle coincides with SETUP/PULSE/HOLD on the same row, that RWL bit shall stay 0 and rdp_data shall return the latched write data (forwarding).
REQ-030 RWLx[i] and WWL[i] shall never be 1 in the same cycle for any i.

Reset
REQ-031 reset=1 at an edge shall force next cycle: all wordlines 0, WBL=WBLb=0, rd0_val=rd1_val=0, rd0_data=rd1_data=0, wr_busy=0, wr_ack=0, FSM=IDLE, counter=0.
REQ-032 Reset during any write state shall abandon the write with no wr_ack; in-flight reads shall produce no rdp_val.
REQ-033 Requests sampled while reset=1 shall be ignored.

Verification
REQ-034 Write addr 5 data 0xA5C, WR_PULSE_CYC=1 -> SETUP WBL=0xA5C WBLb=0x5A3; next cycle WWL=0x0400 (bit 5, MSB-first) one cycle; wr_ack 3 cycles after request.
REQ-035 After REQ-034, rd0 addr 5 and rd1 addr 5 same cycle -> RWL0=RWL1=bit 5 one cycle; both rdp_val with data 0xA5C two cycles after request.
REQ-036 Back-to-back rd0 addrs 0,1,2,3 on consecutive cycles -> RWL0 walks bits 0..3; four consecutive rd0_val pulses with stored data in order.
REQ-037 wr addr 7 data 0x123 with WR_PULSE_CYC=3, rd1 addr 7 issued during PULSE -> RWL1 stays 0, rd1_data=0x123; second wr_req during busy ignored, no extra wr_ack.
REQ-038 reset asserted in PULSE cycle -> next cycle WWL=0, WBL=WBLb=0, wr_busy=0, no wr_ack; subsequent read of that row returns pre-write contents.
